// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg                                                                  |
// | Shared ALU types: unary op codes, default data width, result flag set.   |
// | Used by alu_unary and the binary ALU units.                              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package alu_pkg;

  // Default operand/result width for all ALU units.
  localparam int DATA_WIDTH = 16;

  // Unary op codes. Codes 6 and 7 are reserved and decode as PASS.
  typedef enum logic [2:0] {
    ALU_UN_PASS = 3'd0,
    ALU_UN_NOT  = 3'd1,
    ALU_UN_NEG  = 3'd2,
    ALU_UN_ABS  = 3'd3,
    ALU_UN_INC  = 3'd4,
    ALU_UN_DEC  = 3'd5
  } alu_unary_op_t;

  // Result flags carried alongside every result.
  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_unary_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_unary_core                                                           |
// | Purely combinational unary operator with flag generation.                |
// | Ports:                                                                   |
// |   operand [WIDTH] in  - signed two's complement operand                  |
// |   op      [3]     in  - alu_unary_op_t code (6/7 act as PASS)            |
// |   result  [WIDTH] out - operation result, modulo 2^WIDTH                 |
// |   flags           out - {zero, neg, ovf} of result                       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module alu_unary_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};

  logic [WIDTH-1:0] w_negated;
  logic             w_is_min;
  logic             w_is_max;
  logic             w_ovf;

  assign w_negated = (~operand) + c_one;
  assign w_is_min  = (operand == c_min);
  assign w_is_max  = (operand == c_max);

  always_comb begin
    result = operand;
    w_ovf  = 1'b0;
    case (op)
      ALU_UN_NOT: result = ~operand;
      ALU_UN_NEG: begin
        // -MIN wraps back to MIN
        result = w_negated;
        w_ovf  = w_is_min;
      end
      ALU_UN_ABS: begin
        // |MIN| is not representable and wraps to MIN
        result = operand[WIDTH-1] ? w_negated : operand;
        w_ovf  = w_is_min;
      end
      ALU_UN_INC: begin
        result = operand + c_one;
        w_ovf  = w_is_max;
      end
      ALU_UN_DEC: begin
        result = operand - c_one;
        w_ovf  = w_is_min;
      end
      default: result = operand;
    endcase
  end

  always_comb begin
    flags      = '0;
    flags.zero = (result == '0);
    flags.neg  = result[WIDTH-1];
    flags.ovf  = w_ovf;
  end

endmodule
`default_nettype wire

// File: rtl/alu_unary.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_unary                                                                |
// | Pipelined unary ALU with per-stage valid/ready backpressure.             |
// | Parameters: WIDTH (>=2), STAGES (1..4, equals latency).                  |
// | Ports:                                                                   |
// |   clock, reset_n (async, active low), enable (global advance enable)     |
// |   in_valid/in_ready/in_data/in_op    - operand handshake                 |
// |   out_valid/out_ready/out_data       - result handshake                  |
// |   out_zero/out_neg/out_ovf           - registered result flags          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module alu_unary
  import alu_pkg::*;
#(
  parameter int WIDTH  = DATA_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  logic [WIDTH-1:0]  w_core_data;
  alu_flags_t        w_core_flags;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data  [STAGES];
  alu_flags_t        r_flags [STAGES];

  logic [STAGES-1:0] w_room;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;

  alu_unary_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .operand (in_data),
    .op      (in_op),
    .result  (w_core_data),
    .flags   (w_core_flags)
  );

  // The recursive advance chain unrolls to: a full stage may move on if any
  // later stage is empty or the consumer takes the last result. Evaluating
  // it directly from the valid bits keeps the logic free of comb feedback.
  always_comb begin
    w_room = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_room[i] = out_ready;
      for (int j = i + 1; j < STAGES; j++) begin
        if (!r_valid[j]) begin
          w_room[i] = 1'b1;
        end
      end
    end
  end

  assign w_adv    = {STAGES{enable}} & r_valid & w_room;
  assign w_load   = {STAGES{enable}} & (~r_valid | w_adv);
  assign in_ready = w_load[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_valid[0] <= 1'b0;
          r_data[0]  <= '0;
          r_flags[0] <= '0;
        end else if (w_load[0]) begin
          r_valid[0] <= in_valid;
          // Payload only updates on a real accept; bubbles keep old data
          if (in_valid) begin
            r_data[0]  <= w_core_data;
            r_flags[0] <= w_core_flags;
          end
        end
      end
    end else begin : g_body
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
          r_flags[gi] <= '0;
        end else if (w_load[gi]) begin
          // Upstream advances exactly when it is valid and this stage loads
          r_valid[gi] <= w_adv[gi-1];
          if (w_adv[gi-1]) begin
            r_data[gi]  <= r_data[gi-1];
            r_flags[gi] <= r_flags[gi-1];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_zero  = r_flags[STAGES-1].zero;
  assign out_neg   = r_flags[STAGES-1].neg;
  assign out_ovf   = r_flags[STAGES-1].ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_unary.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_unary                                                             |
// | Directed self-checking bench for alu_unary, WIDTH=8, STAGES=2.           |
// | Inputs change and outputs are sampled around the falling clock edge.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_alu_unary;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  alu_unary #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    reset_n   = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_op     = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_valid, out_data, out_zero, out_neg, out_ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h z=%b n=%b o=%b want all 0",
               out_valid, out_data, out_zero, out_neg, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_en1: got %b want 1", in_ready);
    end
    enable = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_en0: got %b want 0", in_ready);
    end
    enable = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    // Put two results in flight, consumer stalled
    in_valid = 1'b1; in_op = 3'd2; in_data = 8'd5;
    @(negedge clock);
    in_op = 3'd1; in_data = 8'h00;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFB) begin
      errors++;
      $display("FAIL reset_inflight: got v=%b d=%h want v=1 d=fb", out_valid, out_data);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_zero, out_neg, out_ovf} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async_clear: got v=%b d=%h z=%b n=%b o=%b want all 0",
               out_valid, out_data, out_zero, out_neg, out_ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_in_ready: got %b want 1", in_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_release[%0d]: got v=%b rdy=%b want v=0 rdy=1",
                 c, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_stream;
    logic [2:0] ops  [5];
    logic [7:0] din  [5];
    logic [7:0] dexp [5];
    logic [2:0] fexp [5];   // {zero, neg, ovf}
    ops  = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd0};
    din  = '{8'h05, 8'h00, 8'hFF, 8'hF9, 8'h00};
    dexp = '{8'hFB, 8'hFF, 8'h00, 8'h07, 8'h00};
    fexp = '{3'b010, 3'b010, 3'b100, 3'b000, 3'b100};
    out_ready = 1'b1;
    enable    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (c < 5) begin
        in_valid = 1'b1; in_op = ops[c]; in_data = din[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 5) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready[%0d]: got %b want 1", c, in_ready);
        end
      end
      if (c >= 2 && c < 7) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== dexp[c-2]) begin
          errors++;
          $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h",
                   c - 2, out_valid, out_data, dexp[c-2]);
        end
        checks++;
        if ({out_zero, out_neg, out_ovf} !== fexp[c-2]) begin
          errors++;
          $display("FAIL stream_flags[%0d]: got zno=%b want %b",
                   c - 2, {out_zero, out_neg, out_ovf}, fexp[c-2]);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_idle[%0d]: got v=%b want 0", c, out_valid);
        end
      end
    end
  endtask

  task automatic test_overflow;
    logic [2:0] ops  [4];
    logic [7:0] din  [4];
    logic [7:0] dexp [4];
    logic [2:0] fexp [4];
    ops  = '{3'd2, 3'd3, 3'd4, 3'd5};
    din  = '{8'h80, 8'h80, 8'h7F, 8'h80};
    dexp = '{8'h80, 8'h80, 8'h80, 8'h7F};
    fexp = '{3'b011, 3'b011, 3'b011, 3'b001};
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      if (c < 4) begin
        in_valid = 1'b1; in_op = ops[c]; in_data = din[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c < 6) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== dexp[c-2]) begin
          errors++;
          $display("FAIL ovf_data[%0d]: got v=%b d=%h want v=1 d=%h",
                   c - 2, out_valid, out_data, dexp[c-2]);
        end
        checks++;
        if ({out_zero, out_neg, out_ovf} !== fexp[c-2]) begin
          errors++;
          $display("FAIL ovf_flags[%0d]: got zno=%b want %b",
                   c - 2, {out_zero, out_neg, out_ovf}, fexp[c-2]);
        end
      end else if (c == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL ovf_idle: got v=%b want 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_reserved;
    logic [2:0] ops  [2];
    logic [7:0] din  [2];
    logic [7:0] dexp [2];
    logic [2:0] fexp [2];
    ops  = '{3'd6, 3'd7};
    din  = '{8'h80, 8'h00};
    dexp = '{8'h80, 8'h00};
    fexp = '{3'b010, 3'b100};
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c < 2) begin
        in_valid = 1'b1; in_op = ops[c]; in_data = din[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c < 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== dexp[c-2]) begin
          errors++;
          $display("FAIL reserved_data[%0d]: got v=%b d=%h want v=1 d=%h",
                   c - 2, out_valid, out_data, dexp[c-2]);
        end
        checks++;
        if ({out_zero, out_neg, out_ovf} !== fexp[c-2]) begin
          errors++;
          $display("FAIL reserved_flags[%0d]: got zno=%b want %b",
                   c - 2, {out_zero, out_neg, out_ovf}, fexp[c-2]);
        end
      end else if (c == 4) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL reserved_idle: got v=%b want 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    // Per-cycle table: consumer ready, offer valid, op, operand,
    // expected in_ready, expected out_valid, expected out_data
    logic       ordy [9];
    logic       ival [9];
    logic [2:0] op   [9];
    logic [7:0] din  [9];
    logic       eir  [9];
    logic       eov  [9];
    logic [7:0] ed   [9];
    ordy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ival = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    op   = '{3'd4, 3'd5, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    din  = '{8'h0A, 8'h0A, 8'h0F, 8'h0F, 8'h0F, 8'h55, 8'h00, 8'h00, 8'h00};
    eir  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    eov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ed   = '{8'h00, 8'h00, 8'h0B, 8'h0B, 8'h0B, 8'h09, 8'hF0, 8'h55, 8'h00};
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      out_ready = ordy[c];
      in_valid  = ival[c];
      in_op     = op[c];
      in_data   = din[c];
      #1;
      checks++;
      if (in_ready !== eir[c]) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, eir[c]);
      end
      checks++;
      if (out_valid !== eov[c] || (eov[c] && out_data !== ed[c])) begin
        errors++;
        $display("FAIL bp_out[%0d]: got v=%b d=%h want v=%b d=%h",
                 c, out_valid, out_data, eov[c], ed[c]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_enable;
    logic       en   [9];
    logic       ival [9];
    logic [7:0] din  [9];
    logic       eir  [9];
    logic       eov  [9];
    logic [7:0] ed   [9];
    en   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ival = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    din  = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h00, 8'h00, 8'h00};
    eir  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    eov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ed   = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h00};
    out_ready = 1'b1;
    in_op     = 3'd0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      enable   = en[c];
      in_valid = ival[c];
      in_data  = din[c];
      #1;
      checks++;
      if (in_ready !== eir[c]) begin
        errors++;
        $display("FAIL en_in_ready[%0d]: got %b want %b", c, in_ready, eir[c]);
      end
      checks++;
      if (out_valid !== eov[c] || (eov[c] && out_data !== ed[c])) begin
        errors++;
        $display("FAIL en_out[%0d]: got v=%b d=%h want v=%b d=%h",
                 c, out_valid, out_data, eov[c], ed[c]);
      end
    end
    in_valid = 1'b0;
    enable   = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_reserved();
    test_backpressure();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_unary.md
# alu_unary

Parametrised, pipelined unary ALU unit: it generalises the single-function clocked inverter into a multi-mode operator (pass, NOT, negate, abs, increment, decrement) with configurable data width and pipeline depth. Result flags are registered alongside the data, and a valid/ready handshake provides per-stage backpressure. It sits in the ALU beside the binary units. The legacy `enable` input is kept as a global clock-enable.

## Interface
- WIDTH, 16 (`DATA_WIDTH` default): operand/result width in bits, minimum 2.
- STAGES, 2: pipeline register stages, 1..4. This is also the latency in cycles.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global advance enable. When low, the whole pipeline freezes.
- in_valid  in  1  operand present.
- in_ready  out  1  unit accepts the operand this cycle.
- in_data  in  WIDTH  signed operand.
- in_op  in  3  operation code; see Operation.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  signed result.
- out_zero  out  1  out_data == 0.
- out_neg  out  1  out_data MSB.
- out_ovf  out  1  signed overflow of the operation.

## Operation
- Op codes:
  - 0 PASS
  - 1 NOT (~x)
  - 2 NEG (-x)
  - 3 ABS
  - 4 INC (x+1)
  - 5 DEC (x-1)
  - 6 and 7 are reserved and behave as PASS.
- Arithmetic is two's complement, modulo 2^WIDTH. MIN = -2^(WIDTH-1), MAX = 2^(WIDTH-1)-1.
- Overflow cases, all giving out_ovf=1:
  - NEG(MIN) = MIN
  - ABS(MIN) = MIN
  - INC(MAX) = MIN
  - DEC(MIN) = MAX
- PASS and NOT always give out_ovf=0.
- Result and flags are computed combinationally from in_data/in_op and captured in stage 0. Later stages delay them.
- Each stage i holds {valid, data, zero, neg, ovf}.
- Stage advance rule (all terms ANDed with enable):
  - adv[i] = v[i] && (last stage ? out_ready : (!v[i+1] || adv[i+1])).
  - Stage i loads when !v[i] || adv[i].
- in_ready = enable && (!v[0] || adv[0]). Accept = in_valid && in_ready.
- Bubbles collapse: an empty stage loads even when downstream is stalled.
- Results leave strictly in acceptance order. No drop, no duplication.
- out_* is driven directly from the last stage.
- While out_valid=1 and the result is not consumed, out_data and the flags hold stable.

## Timing
- Reset (reset_n low, asynchronous):
  - all valid bits, data and flags clear to 0.
  - out_valid=0, out_data=0, out_zero=0, out_neg=0, out_ovf=0.
  - in_ready = enable (combinational).
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1. That is STAGES cycles of register delay when unstalled.
- Throughput: 1 op/cycle while out_ready=1 and enable=1.
- Capacity: STAGES results are buffered under backpressure. in_ready falls only when every stage is full and the last stage is not draining.
- Simultaneous accept and drain when full: allowed in the same cycle. The pipeline shifts and occupancy is unchanged.
- enable low:
  - no state changes and in_ready=0.
  - out_valid/out_data hold.
  - out_ready is ignored: the result is not consumed.
- Reset mid-stream discards all in-flight results immediately. The first valid output after release is from a post-reset accept.
- STAGES=1: combinational in_ready path through out_ready. This is permitted.

## Structure
- Shared package alu_pkg holds:
  - the alu_unary_op_t enum (3 bits, codes above).
  - the DATA_WIDTH default.
  - the flag struct {zero, neg, ovf}.
  Other ALU units reuse these.
- Sub-module alu_unary_core: purely combinational op + flag generation, parametrised by WIDTH.
- The top level holds the STAGES-deep register/valid chain (generate loop) and the handshake logic.

## Test plan
All scenarios use WIDTH=8, STAGES=2.
1. Reset: assert reset_n=0 mid-cycle with data in flight → all outputs 0 immediately. After release, in_ready=1 (enable=1) and out_valid stays 0 until a new accept.
2. Stream with out_ready=1: send NEG 5, NOT 0, INC -1, ABS -7, PASS 0 → after 2 cycles, one result per cycle, in order:
   - 0xFB (neg=1)
   - 0xFF (neg=1)
   - 0x00 (zero=1)
   - 0x07
   - 0x00 (zero=1)
   - all with ovf=0.
3. Overflow: NEG -128, ABS -128, INC 127, DEC -128 → -128, -128, -128, 127, each with ovf=1. out_neg is 1, 1, 1, 0.
4. Backpressure: out_ready=0 for 4 cycles while offering 4 ops back-to-back → exactly 2 accepted, then in_ready=0. Raising out_ready drains them in order, with the 3rd accepted in the same cycle as the first drain.
5. enable=0 for 3 cycles with a valid output and out_ready=1 → out_data stable, no consumption, in_ready=0. After enable returns, the stream resumes with no loss.
6. Reserved op 6 on 0x80 → 0x80, neg=1, ovf=0.
